pkt_demux: RTL and testbench

PKT_DEMUX -- requirements
Module: pkt_demux

---
 rtl/noc_pkg.sv | 15 +
 rtl/flit_fifo.sv | 47 ++++
 rtl/pkt_demux.sv | 86 ++++++++
 tb/tb_pkt_demux.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit type encodings, width defaults and demux FSM states
package noc_pkg;
    localparam int DATAW_DEF = 66;
    localparam int VCHW_DEF = 1;
    typedef enum logic [1:0] {
        FT_NONE = 2'b00,
        FT_HEAD = 2'b01,
        FT_DATA = 2'b10,
        FT_TAIL = 2'b11
    } ftype_e;
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;
endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: in-order flit queue with a head output that reads zero while empty
module flit_fifo #(
    parameter int W = 67,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout = empty ? '0 : mem_q[rd_q];
    // pointer and occupancy update; a full queue refuses pushes even while popping
    always_comb begin
        do_push = push && !full;
        do_pop = pop && !empty;
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // storage needs no reset because the head output is gated by empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: rtl/pkt_demux.sv
// pkt_demux: steers HEAD..TAIL packets to one of two output FIFOs chosen by the HEAD payload bit 0
module pkt_demux
    import noc_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int VCHW = VCHW_DEF,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    output logic             iready,
    output logic [DATAW-1:0] odata_0,
    output logic             ovalid_0,
    output logic [VCHW-1:0]  ovch_0,
    input  logic             oready_0,
    output logic [DATAW-1:0] odata_1,
    output logic             ovalid_1,
    output logic [VCHW-1:0]  ovch_1,
    input  logic             oready_1,
    output logic [15:0]      pkt_cnt_0,
    output logic [15:0]      pkt_cnt_1,
    output logic             err
);
    localparam int FW = DATAW + VCHW;
    state_e state_q, state_d;
    logic dport_q, dport_d, err_q, err_d;
    logic [VCHW-1:0] vch_q, vch_d, push_vch;
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    ftype_e ftype;
    logic bad, tgt, acc, push;
    logic [1:0] full, empty, pop;
    logic [FW-1:0] dout0, dout1;
    assign ftype = ftype_e'(idata[DATAW-1 -: 2]);
    assign {ovch_0, odata_0} = dout0;
    assign {ovch_1, odata_1} = dout1;
    assign ovalid_0 = !empty[0];
    assign ovalid_1 = !empty[1];
    assign pkt_cnt_0 = cnt0_q;
    assign pkt_cnt_1 = cnt1_q;
    assign err = err_q;
    // protocol decode, handshake, FSM next state and TAIL-pop counting
    always_comb begin
        bad = (state_q == IDLE) ? (ftype == FT_DATA || ftype == FT_TAIL) : (ftype == FT_HEAD);
        tgt = (state_q == IDLE) ? idata[0] : dport_q;
        iready = rst ? 1'b0 : (ftype == FT_NONE || bad) ? 1'b1 : !full[tgt];
        acc = ivalid && iready;
        push = acc && !bad && ftype != FT_NONE;
        push_vch = (ftype == FT_HEAD) ? ivch : vch_q;
        state_d = (push && ftype == FT_HEAD) ? BUSY : (push && ftype == FT_TAIL) ? IDLE : state_q;
        dport_d = (push && ftype == FT_HEAD) ? idata[0] : dport_q;
        vch_d = (push && ftype == FT_HEAD) ? ivch : vch_q;
        err_d = acc && bad;
        pop = {ovalid_1 && oready_1, ovalid_0 && oready_0};
        cnt0_d = (pop[0] && ftype_e'(odata_0[DATAW-1 -: 2]) == FT_TAIL && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
        cnt1_d = (pop[1] && ftype_e'(odata_1[DATAW-1 -: 2]) == FT_TAIL && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
    end
    // FSM, latches, error pulse and packet counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dport_q <= 1'b0;
            vch_q <= '0;
            err_q <= 1'b0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            state_q <= state_d;
            dport_q <= dport_d;
            vch_q <= vch_d;
            err_q <= err_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
    flit_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push(push && !tgt), .din({push_vch, idata}),
        .pop(oready_0), .full(full[0]), .empty(empty[0]), .dout(dout0)
    );
    flit_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push && tgt), .din({push_vch, idata}),
        .pop(oready_1), .full(full[1]), .empty(empty[1]), .dout(dout1)
    );
endmodule

// File: tb/tb_pkt_demux.sv
// tb_pkt_demux: directed packet scenarios checked against a queue-based reference model
module tb_pkt_demux;
    localparam int DATAW = 66;
    localparam int VCHW = 1;
    localparam int DEPTH = 2;
    localparam int FW = DATAW + VCHW;
    localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, DATA = 2'b10, TAIL = 2'b11;
    logic clk = 1'b0, rst = 1'b1;
    logic [DATAW-1:0] idata, odata_0, odata_1;
    logic ivalid, iready, ovalid_0, ovalid_1, oready_0, oready_1, err;
    logic [VCHW-1:0] ivch, ovch_0, ovch_1;
    logic [15:0] pkt_cnt_0, pkt_cnt_1;
    int n_pass = 0, n_total = 0;
    logic [FW-1:0] q0[$], q1[$];
    logic m_busy = 1'b0, m_dport = 1'b0, m_err = 1'b0;
    logic [VCHW-1:0] m_vch = '0;
    logic [15:0] m_cnt0 = '0, m_cnt1 = '0;

    always #5 clk = ~clk;

    pkt_demux dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
        .odata_0(odata_0), .ovalid_0(ovalid_0), .ovch_0(ovch_0), .oready_0(oready_0),
        .odata_1(odata_1), .ovalid_1(ovalid_1), .ovch_1(ovch_1), .oready_1(oready_1),
        .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .err(err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // reference model: checks outputs each cycle, then applies pops and accepted pushes
    always @(negedge clk) begin
        logic [1:0] t;
        logic none, bad, tgt, exp_ir, acc;
        logic [FW-1:0] hd;
        t = idata[65:64];
        none = (t == NONE);
        bad = m_busy ? (t == HEAD) : (t == DATA || t == TAIL);
        tgt = m_busy ? m_dport : idata[0];
        exp_ir = rst ? 1'b0 : (none || bad) ? 1'b1 : ((tgt ? q1.size() : q0.size()) < DEPTH);
        chk("iready", iready, exp_ir);
        chk("ovalid_0", ovalid_0, q0.size() != 0);
        chk("ovalid_1", ovalid_1, q1.size() != 0);
        if (q0.size() != 0) chk("head_0", {ovch_0, odata_0}, q0[0]);
        if (q1.size() != 0) chk("head_1", {ovch_1, odata_1}, q1[0]);
        chk("err", err, m_err);
        chk("pkt_cnt_0", pkt_cnt_0, m_cnt0);
        chk("pkt_cnt_1", pkt_cnt_1, m_cnt1);
        if (rst) begin
            q0.delete();
            q1.delete();
            m_busy = 1'b0;
            m_dport = 1'b0;
            m_vch = '0;
            m_err = 1'b0;
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            if (oready_0 && q0.size() != 0) begin
                hd = q0.pop_front();
                if (hd[65:64] == TAIL && m_cnt0 != 16'hFFFF) m_cnt0++;
            end
            if (oready_1 && q1.size() != 0) begin
                hd = q1.pop_front();
                if (hd[65:64] == TAIL && m_cnt1 != 16'hFFFF) m_cnt1++;
            end
            acc = ivalid && exp_ir;
            m_err = acc && bad;
            if (acc && !none && !bad) begin
                if (t == HEAD) begin
                    m_dport = idata[0];
                    m_vch = ivch;
                end
                if (m_dport) q1.push_back({m_vch, idata});
                else q0.push_back({m_vch, idata});
                m_busy = (t != TAIL);
            end
        end
    end

    task automatic send(input logic [1:0] t, input logic [63:0] p, input logic [VCHW-1:0] v);
        int n = 0;
        idata = {t, p};
        ivch = v;
        ivalid = 1'b1;
        @(negedge clk);
        while (!iready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", n < 200, 1'b1);
        @(posedge clk);
        #1 ivalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((ovalid_0 || ovalid_1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 200, 1'b1);
    endtask

    initial begin
        #2000000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idata = '0; ivalid = 1'b0; ivch = '0; oready_0 = 1'b0; oready_1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_iready", iready, 1'b0);
        chk("rst_odata_0", odata_0, '0);
        chk("rst_odata_1", odata_1, '0);
        chk("rst_ovch", {ovch_1, ovch_0}, '0);
        rst = 1'b0;
        // long packet to port 0
        oready_0 = 1'b1;
        send(HEAD, 64'h08, 1'b0);
        for (int i = 0; i < 20; i++) send(DATA, 64'h100 + 64'(i), 1'b1);
        send(TAIL, 64'h2FF, 1'b1);
        drain();
        chk("pkt_cnt_0_long", pkt_cnt_0, 16'd1);
        chk("pkt_cnt_1_long", pkt_cnt_1, 16'd0);
        // port 1 backpressure with VC 1
        send(HEAD, 64'h05, 1'b1);
        send(DATA, 64'hA1, 1'b0);
        idata = {DATA, 64'hA2};
        ivch = 1'b0;
        ivalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("iready_full", iready, 1'b0);
        end
        chk("ovch_1_held", ovch_1, 1'b1);
        @(posedge clk);
        #1 oready_1 = 1'b1;
        send(DATA, 64'hA2, 1'b0);
        send(TAIL, 64'hA3, 1'b0);
        drain();
        chk("pkt_cnt_1_bp", pkt_cnt_1, 16'd1);
        // protocol errors and NONE flits
        send(DATA, 64'h77, 1'b0);
        chk("err_pulse", err, 1'b1);
        @(posedge clk);
        #1 chk("err_clear", err, 1'b0);
        send(HEAD, 64'h10, 1'b0);
        send(NONE, 64'h11, 1'b0);
        chk("none_no_err", err, 1'b0);
        send(HEAD, 64'h13, 1'b1);
        chk("head_busy_err", err, 1'b1);
        send(TAIL, 64'h14, 1'b0);
        drain();
        chk("pkt_cnt_0_err", pkt_cnt_0, 16'd2);
        // stalled port 1 must not block port 0
        oready_1 = 1'b0;
        send(HEAD, 64'h21, 1'b1);
        send(TAIL, 64'h22, 1'b0);
        send(HEAD, 64'h30, 1'b0);
        for (int i = 0; i < 3; i++) send(DATA, 64'h31 + 64'(i), 1'b0);
        send(TAIL, 64'h3F, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (ovalid_0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("port0_drain_timeout", n < 200, 1'b1);
        end
        chk("port1_held_valid", ovalid_1, 1'b1);
        chk("port1_held_data", odata_1, {HEAD, 64'h21});
        chk("pkt_cnt_0_indep", pkt_cnt_0, 16'd3);
        @(posedge clk);
        #1 oready_1 = 1'b1;
        drain();
        chk("pkt_cnt_1_indep", pkt_cnt_1, 16'd2);
        // reset in mid-packet
        send(HEAD, 64'h40, 1'b1);
        for (int i = 0; i < 5; i++) send(DATA, 64'h41 + 64'(i), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ovalid", {ovalid_1, ovalid_0}, 2'b00);
        chk("mid_rst_odata", {odata_1, odata_0}, '0);
        chk("mid_rst_cnt", {pkt_cnt_1, pkt_cnt_0}, '0);
        chk("mid_rst_err_iready", {err, iready}, 2'b00);
        rst = 1'b0;
        send(HEAD, 64'h51, 1'b0);
        send(DATA, 64'h52, 1'b1);
        send(TAIL, 64'h53, 1'b1);
        drain();
        chk("post_rst_cnt_1", pkt_cnt_1, 16'd1);
        chk("post_rst_cnt_0", pkt_cnt_0, 16'd0);
        // counter saturation
        @(posedge clk);
        #1;
        force dut.cnt0_q = 16'hFFFE;
        m_cnt0 = 16'hFFFE;
        @(posedge clk);
        #1 release dut.cnt0_q;
        chk("preload_cnt_0", pkt_cnt_0, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            send(HEAD, 64'h60 + 64'(2 * i), 1'b0);
            send(TAIL, 64'h61 + 64'(2 * i), 1'b0);
        end
        drain();
        chk("sat_cnt_0", pkt_cnt_0, 16'hFFFF);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
